// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: control FSM for a multicycle CPU.
// Each instruction is sequenced through IF/ID/EXE/MEM/WB. The FSM drives the
// ALU controls and every datapath enable and mux select. All outputs are
// decoded combinationally from the state register, the latched opcode and the
// ALU status flags.
// Optional build macro CU_ILLEGAL_TRAP_EN: when defined, an unknown opcode
// traps to HALT and raises a sticky 'illegal' flag. When undefined, an unknown
// opcode executes as a 2-cycle NOP and 'illegal' is tied low.
module multi_cycle_control_unit #(
    parameter int OPW = 6,
    parameter int STW = 3
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           sign,
    output logic           PCWre,
    output logic           IRWre,
    output logic           RegWre,
    output logic           mRD,
    output logic           mWR,
    output logic           ExtSel,
    output logic           ALUSrcA,
    output logic           ALUSrcB,
    output logic [2:0]     ALUop,
    output logic [1:0]     RegDst,
    output logic           WrRegDSrc,
    output logic           DBDataSrc,
    output logic [1:0]     PCSrc,
    output logic [STW-1:0] state,
    output logic           illegal
);

    typedef enum logic [STW-1:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b111
    } state_t;

    localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
    localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
    localparam logic [OPW-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OPW-1:0] OP_AND   = 6'b010000;
    localparam logic [OPW-1:0] OP_ANDI  = 6'b010001;
    localparam logic [OPW-1:0] OP_ORI   = 6'b010010;
    localparam logic [OPW-1:0] OP_XORI  = 6'b010011;
    localparam logic [OPW-1:0] OP_SLL   = 6'b011000;
    localparam logic [OPW-1:0] OP_SLTI  = 6'b100110;
    localparam logic [OPW-1:0] OP_SLT   = 6'b100111;
    localparam logic [OPW-1:0] OP_SW    = 6'b110000;
    localparam logic [OPW-1:0] OP_LW    = 6'b110001;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OPW-1:0] OP_BNE   = 6'b110101;
    localparam logic [OPW-1:0] OP_BLTZ  = 6'b110110;
    localparam logic [OPW-1:0] OP_J     = 6'b111000;
    localparam logic [OPW-1:0] OP_JR    = 6'b111001;
    localparam logic [OPW-1:0] OP_JAL   = 6'b111010;
    localparam logic [OPW-1:0] OP_HALT  = 6'b111111;

    state_t state_q;
    state_t state_d;

    logic op_add, op_sub, op_addiu, op_and, op_andi, op_ori, op_xori, op_sll;
    logic op_slti, op_slt, op_sw, op_lw, op_beq, op_bne, op_bltz;
    logic op_j, op_jr, op_jal, op_halt;
    logic is_rtype_s, is_branch_s, is_jump_s, is_known_s, branch_taken_s;

    assign op_add   = (opcode == OP_ADD);
    assign op_sub   = (opcode == OP_SUB);
    assign op_addiu = (opcode == OP_ADDIU);
    assign op_and   = (opcode == OP_AND);
    assign op_andi  = (opcode == OP_ANDI);
    assign op_ori   = (opcode == OP_ORI);
    assign op_xori  = (opcode == OP_XORI);
    assign op_sll   = (opcode == OP_SLL);
    assign op_slti  = (opcode == OP_SLTI);
    assign op_slt   = (opcode == OP_SLT);
    assign op_sw    = (opcode == OP_SW);
    assign op_lw    = (opcode == OP_LW);
    assign op_beq   = (opcode == OP_BEQ);
    assign op_bne   = (opcode == OP_BNE);
    assign op_bltz  = (opcode == OP_BLTZ);
    assign op_j     = (opcode == OP_J);
    assign op_jr    = (opcode == OP_JR);
    assign op_jal   = (opcode == OP_JAL);
    assign op_halt  = (opcode == OP_HALT);

    assign is_rtype_s  = op_add | op_sub | op_and | op_sll | op_slt;
    assign is_branch_s = op_beq | op_bne | op_bltz;
    assign is_jump_s   = op_j | op_jr | op_jal;
    assign is_known_s  = is_rtype_s | is_branch_s | is_jump_s | op_halt |
                         op_addiu | op_andi | op_ori | op_xori | op_slti |
                         op_sw | op_lw;

    // Branch condition; zero/sign only reach an output through the EXE-state PCSrc decode.
    assign branch_taken_s = (op_beq & zero) | (op_bne & ~zero) | (op_bltz & sign);

    // Next-state selection for the instruction sequencer.
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:   state_d = S_ID;
            S_ID: begin
                if (is_jump_s) begin
                    state_d = S_IF;
                end else if (op_halt) begin
                    state_d = S_HALT;
                end else if (!is_known_s) begin
`ifdef CU_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_IF;
`endif
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (is_branch_s) begin
                    state_d = S_IF;
                end else if (op_lw | op_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (op_sw) begin
                    state_d = S_IF;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // State register; reset aborts any in-flight instruction back to IF.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky trap flag: set when an unknown opcode is decoded, cleared only by reset.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            illegal_q <= 1'b0;
        end else if ((state_q == S_ID) && !is_known_s) begin
            illegal_q <= 1'b1;
        end else begin
            illegal_q <= illegal_q;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Datapath control decode; write enables are masked while Reset is low.
    always_comb begin
        IRWre     = Reset & (state_q == S_IF);
        PCWre     = Reset & (state_d == S_IF);
        RegWre    = Reset & ((state_q == S_WB) | ((state_q == S_ID) & op_jal));
        mRD       = Reset & (state_q == S_MEM) & op_lw;
        mWR       = Reset & (state_q == S_MEM) & op_sw;
        ExtSel    = ~(op_andi | op_ori | op_xori);
        ALUSrcA   = op_sll;
        ALUSrcB   = op_addiu | op_andi | op_ori | op_xori | op_slti | op_lw | op_sw;
        WrRegDSrc = ~op_jal;
        DBDataSrc = op_lw;

        ALUop = 3'b000;
        if (op_sub | is_branch_s) begin
            ALUop = 3'b001;
        end else if (op_sll) begin
            ALUop = 3'b010;
        end else if (op_ori) begin
            ALUop = 3'b011;
        end else if (op_and | op_andi) begin
            ALUop = 3'b100;
        end else if (op_slt | op_slti) begin
            ALUop = 3'b110;
        end else if (op_xori) begin
            ALUop = 3'b111;
        end else begin
            ALUop = 3'b000;
        end

        RegDst = 2'b01;
        if (op_jal) begin
            RegDst = 2'b00;
        end else if (is_rtype_s) begin
            RegDst = 2'b10;
        end else begin
            RegDst = 2'b01;
        end

        PCSrc = 2'b00;
        if (op_j | op_jal) begin
            PCSrc = 2'b11;
        end else if (op_jr) begin
            PCSrc = 2'b10;
        end else if ((state_q == S_EXE) && branch_taken_s) begin
            PCSrc = 2'b01;
        end else begin
            PCSrc = 2'b00;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Self-checking bench for multi_cycle_control_unit: directed vector table,
// hand-written corner sequences (reset, mid-instruction reset, halt, unknown
// opcode) and randomized instruction streams checked against a path-based model.
module tb_multi_cycle_control_unit;

    localparam logic [2:0] ST_IF = 3'b000, ST_ID = 3'b001, ST_EXE = 3'b010;
    localparam logic [2:0] ST_MEM = 3'b011, ST_WB = 3'b100, ST_HALT = 3'b111;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDIU = 6'b000010;
    localparam logic [5:0] AND_ = 6'b010000, ANDI = 6'b010001, ORI = 6'b010010;
    localparam logic [5:0] XORI = 6'b010011, SLL = 6'b011000, SLTI = 6'b100110;
    localparam logic [5:0] SLT = 6'b100111, SW = 6'b110000, LW = 6'b110001;
    localparam logic [5:0] BEQ = 6'b110100, BNE = 6'b110101, BLTZ = 6'b110110;
    localparam logic [5:0] J = 6'b111000, JR = 6'b111001, JAL = 6'b111010;
    localparam logic [5:0] HALT = 6'b111111, BAD = 6'b101010;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] opcode;
    logic       zero, sign;
    logic       PCWre, IRWre, RegWre, mRD, mWR, ExtSel, ALUSrcA, ALUSrcB;
    logic [2:0] ALUop;
    logic [1:0] RegDst;
    logic       WrRegDSrc, DBDataSrc;
    logic [1:0] PCSrc;
    logic [2:0] state;
    logic       illegal;

    multi_cycle_control_unit #(.OPW(6), .STW(3)) dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .mRD(mRD), .mWR(mWR),
        .ExtSel(ExtSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
        .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
        .PCSrc(PCSrc), .state(state), .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    // Observed outputs packed in the same order as exp_vec builds them.
    logic [20:0] act;
    assign act = {PCWre, IRWre, RegWre, mRD, mWR, ExtSel, ALUSrcA, ALUSrcB, ALUop,
                  RegDst, WrRegDSrc, DBDataSrc, PCSrc, state, illegal};

    int total = 0;
    int bad = 0;
    logic ill_exp = 1'b0;
    logic [2:0] path_q[$];

    typedef struct {
        logic [5:0] opc;
        logic       z;
        logic       s;
        int         ncyc;
        logic [1:0] pc_last;
        logic       rw_last;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    function automatic logic is_known(input logic [5:0] o);
        return o inside {ADD, SUB, ADDIU, AND_, ANDI, ORI, XORI, SLL, SLTI, SLT,
                         SW, LW, BEQ, BNE, BLTZ, J, JR, JAL, HALT};
    endfunction

    // Expected output vector from the instruction-level rules.
    function automatic logic [20:0] exp_vec(input logic [2:0] st, input logic [5:0] o,
                                            input logic z, input logic s, input logic last,
                                            input logic rst, input logic ill);
        logic pcw, irw, rw, rd, wr, ext, sa, sb, wsrc, dsrc;
        logic [2:0] aop;
        logic [1:0] rdst, pcs;
        pcw  = rst & last & (st != ST_HALT);
        irw  = rst & (st == ST_IF);
        rw   = rst & ((st == ST_WB) | ((st == ST_ID) & (o == JAL)));
        rd   = rst & (st == ST_MEM) & (o == LW);
        wr   = rst & (st == ST_MEM) & (o == SW);
        ext  = !(o inside {ANDI, ORI, XORI});
        sa   = (o == SLL);
        sb   = o inside {ADDIU, ANDI, ORI, XORI, SLTI, LW, SW};
        wsrc = (o != JAL);
        dsrc = (o == LW);
        if (o inside {SUB, BEQ, BNE, BLTZ}) aop = 3'd1;
        else if (o == SLL) aop = 3'd2;
        else if (o == ORI) aop = 3'd3;
        else if (o inside {AND_, ANDI}) aop = 3'd4;
        else if (o inside {SLT, SLTI}) aop = 3'd6;
        else if (o == XORI) aop = 3'd7;
        else aop = 3'd0;
        if (o == JAL) rdst = 2'b00;
        else if (o inside {ADD, SUB, AND_, SLL, SLT}) rdst = 2'b10;
        else rdst = 2'b01;
        if (o inside {J, JAL}) pcs = 2'b11;
        else if (o == JR) pcs = 2'b10;
        else if (st == ST_EXE && ((o == BEQ && z) || (o == BNE && !z) || (o == BLTZ && s)))
            pcs = 2'b01;
        else pcs = 2'b00;
        return {pcw, irw, rw, rd, wr, ext, sa, sb, aop, rdst, wsrc, dsrc, pcs, st, ill};
    endfunction

    // The sequence of states an instruction walks through, starting at IF.
    task automatic build_path(input logic [5:0] o);
        path_q = {ST_IF, ST_ID};
        if (o inside {J, JR, JAL}) return;
        if (o == HALT) begin path_q.push_back(ST_HALT); return; end
        if (!is_known(o)) begin
`ifdef CU_ILLEGAL_TRAP_EN
            path_q.push_back(ST_HALT);
`endif
            return;
        end
        path_q.push_back(ST_EXE);
        if (o inside {BEQ, BNE, BLTZ}) return;
        if (o == LW) begin path_q.push_back(ST_MEM); path_q.push_back(ST_WB); end
        else if (o == SW) path_q.push_back(ST_MEM);
        else path_q.push_back(ST_WB);
    endtask

    // Run one instruction from IF; called at posedge+1, returns at posedge+1.
    task automatic run_instr(input logic [5:0] o, input logic z, input logic s, input bit rnd,
                             output int ncyc, output logic [1:0] pc_last, output logic rw_last);
        logic [20:0] e;
        build_path(o);
        ncyc = 0; pc_last = 2'b00; rw_last = 1'b0;
        for (int k = 0; k < path_q.size(); k++) begin
            opcode = o;
            if (rnd) begin
                zero = 1'($urandom_range(0, 1));
                sign = 1'($urandom_range(0, 1));
            end else begin
                zero = z;
                sign = s;
            end
            #1;
            if (path_q[k] == ST_HALT && !is_known(o)) ill_exp = 1'b1;
            e = exp_vec(path_q[k], o, zero, sign, (k == path_q.size() - 1), 1'b1, ill_exp);
            check($sformatf("op%b_cyc%0d", o, k), {11'd0, act}, {11'd0, e});
            if (PCWre === 1'b1 && ncyc == 0) begin
                ncyc = k + 1; pc_last = PCSrc; rw_last = RegWre;
            end
            @(posedge CLK); #1;
        end
    endtask

    // Assert reset for n cycles, checking reset-state outputs; returns at posedge+1 with Reset high.
    task automatic do_reset(input int n);
        Reset = 1'b0;
        ill_exp = 1'b0;
        for (int i = 0; i < n; i++) begin
            opcode = (i == 0) ? JAL : SW;
            #1;
            check("reset_state", {11'd0, act},
                  {11'd0, exp_vec(ST_IF, opcode, zero, sign, 1'b0, 1'b0, 1'b0)});
            @(posedge CLK); #1;
        end
        Reset = 1'b1;
    endtask

    vec_t vt[$];
    int nc;
    logic [1:0] pl;
    logic rl;
    logic [5:0] ro;
    logic [5:0] rops[18];

    initial begin
        Reset = 1'b0; opcode = ADD; zero = 1'b0; sign = 1'b0;
        rops = '{ADD, SUB, ADDIU, AND_, ANDI, ORI, XORI, SLL, SLTI, SLT,
                 SW, LW, BEQ, BNE, BLTZ, J, JR, JAL};

        vt.push_back('{ADD,   1'b0, 1'b0, 4, 2'b00, 1'b1});
        vt.push_back('{LW,    1'b0, 1'b0, 5, 2'b00, 1'b1});
        vt.push_back('{SW,    1'b0, 1'b0, 4, 2'b00, 1'b0});
        vt.push_back('{BEQ,   1'b1, 1'b0, 3, 2'b01, 1'b0});
        vt.push_back('{BEQ,   1'b0, 1'b1, 3, 2'b00, 1'b0});
        vt.push_back('{BNE,   1'b0, 1'b0, 3, 2'b01, 1'b0});
        vt.push_back('{BNE,   1'b1, 1'b1, 3, 2'b00, 1'b0});
        vt.push_back('{BLTZ,  1'b0, 1'b1, 3, 2'b01, 1'b0});
        vt.push_back('{BLTZ,  1'b1, 1'b0, 3, 2'b00, 1'b0});
        vt.push_back('{J,     1'b0, 1'b0, 2, 2'b11, 1'b0});
        vt.push_back('{JR,    1'b0, 1'b0, 2, 2'b10, 1'b0});
        vt.push_back('{JAL,   1'b0, 1'b0, 2, 2'b11, 1'b1});
        vt.push_back('{SLL,   1'b1, 1'b1, 4, 2'b00, 1'b1});
        vt.push_back('{XORI,  1'b0, 1'b0, 4, 2'b00, 1'b1});
`ifndef CU_ILLEGAL_TRAP_EN
        vt.push_back('{BAD,   1'b0, 1'b0, 2, 2'b00, 1'b0});
`endif

        // Power-on reset for 3 cycles, then release.
        @(posedge CLK); #1;
        do_reset(3);

        // Directed table.
        foreach (vt[i]) begin
            run_instr(vt[i].opc, vt[i].z, vt[i].s, 1'b0, nc, pl, rl);
            check($sformatf("tbl%0d_cycles", i), nc, vt[i].ncyc);
            check($sformatf("tbl%0d_pcsrc", i), {30'd0, pl}, {30'd0, vt[i].pc_last});
            check($sformatf("tbl%0d_regwre", i), {31'd0, rl}, {31'd0, vt[i].rw_last});
        end

        // Reset asserted during the MEM cycle of lw: no memory read, back to IF at once.
        opcode = LW;
        for (int i = 0; i < 3; i++) begin @(posedge CLK); #1; end
        check("lw_mem_mrd", {31'd0, mRD}, 32'd1);
        Reset = 1'b0;
        #1;
        check("midreset", {11'd0, act}, {11'd0, exp_vec(ST_IF, LW, zero, sign, 1'b0, 1'b0, 1'b0)});
        @(posedge CLK); #1;
        do_reset(1);

        // Halt: stays in HALT with no enables whatever the inputs do.
        run_instr(HALT, 1'b0, 1'b0, 1'b0, nc, pl, rl);
        for (int i = 0; i < 5; i++) begin
            opcode = (i == 1) ? BAD : 6'($urandom_range(0, 63));
            zero = 1'($urandom_range(0, 1));
            sign = 1'($urandom_range(0, 1));
            #1;
            check("halt_hold", {11'd0, act},
                  {11'd0, exp_vec(ST_HALT, opcode, zero, sign, 1'b0, 1'b1, 1'b0)});
            @(posedge CLK); #1;
        end
        do_reset(2);

        // Unknown opcode: trap to HALT with sticky flag, or a 2-cycle NOP.
        run_instr(BAD, 1'b0, 1'b0, 1'b0, nc, pl, rl);
`ifdef CU_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            opcode = (i == 0) ? ADD : BAD;
            #1;
            check("trap_hold", {11'd0, act},
                  {11'd0, exp_vec(ST_HALT, opcode, zero, sign, 1'b0, 1'b1, 1'b1)});
            @(posedge CLK); #1;
        end
        do_reset(1);
`else
        check("bad_nop_cycles", nc, 2);
`endif

        // Randomized instruction stream with per-cycle random zero/sign.
        for (int n = 0; n < 150; n++) begin
            ro = rops[$urandom_range(0, 17)];
`ifndef CU_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0) begin
                ro = 6'($urandom_range(0, 63));
                if (ro == HALT) ro = BAD;
            end
`endif
            run_instr(ro, 1'b0, 1'b0, 1'b1, nc, pl, rl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
- Multicycle-CPU control FSM that drives the ALU control interface (ALUop, ALUSrcA, ALUSrcB) and consumes its status outputs (zero, sign).
- Sequences every instruction through IF/ID/EXE/MEM/WB.
- Produces all datapath enables and mux selects for PC, instruction register, register file, extender and data memory.

Parameters:
- OPW, 6, opcode width.
- STW, 3, state register width.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- opcode  input  OPW  IR[31:26] of the latched instruction.
- zero  input  1  ALU result==0.
- sign  input  1  ALU result negative.
- PCWre  output  1  PC write enable.
- IRWre  output  1  IR load enable.
- RegWre  output  1  register-file write enable.
- mRD  output  1  data-memory read.
- mWR  output  1  data-memory write.
- ExtSel  output  1  1=sign-extend, 0=zero-extend imm16.
- ALUSrcA  output  1  1=shamt, 0=rs.
- ALUSrcB  output  1  1=extended imm, 0=rt.
- ALUop  output  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 sltu, 110 slt, 111 xor.
- RegDst  output  2  00=$31, 01=rt, 10=rd.
- WrRegDSrc  output  1  0=PC+4, 1=DB.
- DBDataSrc  output  1  0=ALU result, 1=memory.
- PCSrc  output  2  00 PC+4, 01 PC+4+(imm<<2), 10 rs, 11 jump target.
- state  output  STW  current state, debug.
- illegal  output  1  unknown opcode flag.

Behaviour:
- Opcodes:
  - add 000000, sub 000001, addiu 000010
  - and 010000, andi 010001, ori 010010, xori 010011
  - sll 011000, slti 100110, slt 100111
  - sw 110000, lw 110001
  - beq 110100, bne 110101, bltz 110110
  - j 111000, jr 111001, jal 111010, halt 111111
- State encoding: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111. The state register is the only storage.
- Reset low:
  - state=IF asynchronously.
  - PCWre, IRWre, RegWre, mRD, mWR forced 0 while low.
  - Other outputs decode normally.
- First rising edge after Reset deasserts moves IF->ID.
- Transitions:
  - IF->ID.
  - ID: j/jr/jal->IF; halt->HALT; else EXE.
  - EXE: beq/bne/bltz->IF; lw/sw->MEM; else WB.
  - MEM: sw->IF; lw->WB.
  - WB->IF.
  - HALT stays HALT until reset.
- Outputs are combinational from state, opcode, zero and sign.
- IRWre=1 only in IF.
- PCWre=1 only in the final cycle of an instruction (the cycle whose next state is IF); 0 in HALT.
- Cycle counts:
  - j/jr/jal: 2
  - branches: 3
  - sw: 4
  - R/I arithmetic: 4
  - lw: 5
- RegWre=1 in WB, and in ID for jal (RegDst=00, WrRegDSrc=0).
- Otherwise WrRegDSrc=1; RegDst=01 for I-type/lw, 10 for R-type.
- mRD=1 in MEM for lw; mWR=1 in MEM for sw.
- DBDataSrc=1 for lw only.
- ALUSrcA=1 for sll only.
- ALUSrcB=1 for addiu, andi, ori, xori, slti, lw, sw.
- ExtSel=0 for andi, ori, xori; 1 otherwise.
- ALUop mapping:
  - add/addiu/lw/sw 000
  - sub/beq/bne/bltz 001
  - sll 010
  - or/ori 011
  - and/andi 100
  - slt/slti 110
  - xori 111
- ALUop, ALUSrcA/B are held stable from ID through WB.
- PCSrc:
  - j/jal 11; jr 10.
  - In EXE: beq->01 if zero=1; bne->01 if zero=0; bltz->01 if sign=1; else 00.
  - All others 00.
- zero and sign are sampled only in branch EXE; glitches elsewhere are ignored.
- Reset asserted mid-instruction: abort immediately, no partial register or memory write.

Optional Feature:
- CU_ILLEGAL_TRAP_EN defined: an unknown opcode in ID goes to HALT with illegal=1, held until reset.
- Undefined: an unknown opcode is a 2-cycle NOP (ID->IF, PCWre=1, PCSrc=00, no writes); illegal tied 0.

Test Plan:
- Reset low for 3 cycles, release -> state=000, IRWre=1 first cycle, then state=001; no PCWre/RegWre/mWR pulse during reset.
- add (000000) -> states 000,001,010,100,000; ALUop=000, RegDst=10, RegWre=1 only in WB, PCWre=1 only in WB.
- lw (110001) -> 5 cycles; ALUSrcB=1, ExtSel=1, mRD=1 in MEM, DBDataSrc=1, RegDst=01, RegWre in WB.
- beq with zero=1 then zero=0; bltz with sign=1 -> in EXE PCSrc=01, 00, 01 respectively; PCWre=1 in EXE; 3 cycles each.
- jal (111010) -> ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1; next state IF.
- halt then opcode 101010 (with and without CU_ILLEGAL_TRAP_EN) -> halt stays 111 with no enables; 101010 gives HALT + illegal=1 when defined, else 2-cycle NOP with PCWre=1.
